// File: rtl/nios2_c_cpu_oci_tb_pkg.sv
// Shared types and parameter defaults for the OCI trace monitor.
package nios2_c_cpu_oci_tb_pkg;

    localparam int unsigned BufWDefault  = 30;
    localparam int unsigned CntWDefault  = 4;
    localparam int unsigned SlotWDefault = 2;
    localparam int unsigned DepthDefault = 8;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StEnded
    } state_e;

endpackage

// File: rtl/nios2_c_cpu_oci_tb_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is zero while empty.
module nios2_c_cpu_oci_tb_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == FullLevel);
    assign o_level = r_level;
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios2_c_cpu_oci_trace_monitor.sv
// Captures DCT trace words into a FIFO and drains them until the test ends.
// Define OCI_TB_SLOT_CHECK_EN to flag malformed words on slot_err.
module nios2_c_cpu_oci_trace_monitor
    import nios2_c_cpu_oci_tb_pkg::*;
#(
    parameter int unsigned BUF_W  = BufWDefault,
    parameter int unsigned CNT_W  = CntWDefault,
    parameter int unsigned SLOT_W = SlotWDefault,
    parameter int unsigned DEPTH  = DepthDefault
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUF_W-1:0]       dct_buffer,
    input  logic [CNT_W-1:0]       dct_count,
    input  logic                   dct_valid,
    input  logic                   test_ending,
    output logic [BUF_W-1:0]       out_buffer,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   test_has_ended,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            overflow_cnt,
    output logic [31:0]            total_slots,
    output logic                   slot_err
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SLOT_W == 0 || SLOT_W > BUF_W)
    begin : g_param_check
        $error("DEPTH must be a power of 2 >= 2 and SLOT_W within 1..BUF_W");
    end

    state_e             r_state;
    state_e             w_state_next;
    logic [15:0]        r_overflow_cnt;
    logic [31:0]        r_total_slots;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_empty;
    logic               w_full;
    logic [BUF_W+CNT_W-1:0] w_rdata;

    assign w_accept = (r_state == StRun) && dct_valid && (dct_count != '0);
    assign w_pop    = !w_empty && out_ready;
    assign w_push   = w_accept && (!w_full || w_pop);
    assign w_drop   = w_accept && w_full && !w_pop;

    nios2_c_cpu_oci_tb_fifo #(
        .WIDTH (BUF_W + CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata ({dct_count, dct_buffer}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (level)
    );

    assign out_buffer     = w_rdata[BUF_W-1:0];
    assign out_count      = w_rdata[BUF_W +: CNT_W];
    assign out_valid      = !w_empty;
    assign test_has_ended = (r_state == StEnded);
    assign overflow_cnt   = r_overflow_cnt;
    assign total_slots    = r_total_slots;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StRun:   if (test_ending) w_state_next = StFlush;
            StFlush: if (w_empty)     w_state_next = StEnded;
            StEnded: w_state_next = StEnded;
            default: w_state_next = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= StRun;
            r_overflow_cnt <= '0;
            r_total_slots  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_drop && r_overflow_cnt != 16'hFFFF) begin
                r_overflow_cnt <= r_overflow_cnt + 16'd1;
            end
            if (w_push) begin
                r_total_slots <= r_total_slots + 32'(dct_count);
            end
        end
    end

`ifdef OCI_TB_SLOT_CHECK_EN
    localparam int unsigned DCT_SLOTS = BUF_W / SLOT_W;

    logic w_slot_bad;
    logic r_slot_err;

    // Any set bit at or above slot dct_count is outside the declared payload.
    always_comb begin
        w_slot_bad = (int'(dct_count) > int'(DCT_SLOTS));
        for (int i = 0; i < int'(BUF_W); i++) begin
            if (dct_buffer[i] && (i >= int'(dct_count) * int'(SLOT_W))) begin
                w_slot_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_err <= 1'b0;
        end else if (w_accept && w_slot_bad) begin
            r_slot_err <= 1'b1;
        end
    end

    assign slot_err = r_slot_err;
`else
    assign slot_err = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_c_cpu_oci_trace_monitor.sv
// Directed self-checking bench for the OCI trace monitor (default parameters).
module tb_nios2_c_cpu_oci_trace_monitor;
    import nios2_c_cpu_oci_tb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        test_ending;
    logic [29:0] out_buffer;
    logic [3:0]  out_count;
    logic        out_valid;
    logic        out_ready;
    logic        test_has_ended;
    logic [3:0]  level;
    logic [15:0] overflow_cnt;
    logic [31:0] total_slots;
    logic        slot_err;

    int checks = 0;
    int failures = 0;

`ifdef OCI_TB_SLOT_CHECK_EN
    localparam logic ExpSlotErr = 1'b1;
`else
    localparam logic ExpSlotErr = 1'b0;
`endif

    nios2_c_cpu_oci_trace_monitor dut (
        .clk            (clk),
        .reset          (reset),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .test_ending    (test_ending),
        .out_buffer     (out_buffer),
        .out_count      (out_count),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .test_has_ended (test_has_ended),
        .level          (level),
        .overflow_cnt   (overflow_cnt),
        .total_slots    (total_slots),
        .slot_err       (slot_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [29:0] b, input logic [3:0] c);
        dct_valid  = v;
        dct_buffer = b;
        dct_count  = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [29:0] ovf_word(input int i);
        return 30'h0ABC_0000 + 30'(i);
    endfunction

    task automatic test_reset();
        drive(1'b0, 30'h0, 4'h0);
        test_ending = 1'b0;
        out_ready   = 1'b0;
        do_reset();
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_buffer !== 30'h0 || out_count !== 4'h0) begin failures++; $display("FAIL reset_out_data got %h/%h want 0/0", out_buffer, out_count); end
        checks++; if (overflow_cnt !== 16'd0 || total_slots !== 32'd0) begin failures++; $display("FAIL reset_counters got %0d/%0d want 0/0", overflow_cnt, total_slots); end
        checks++; if (test_has_ended !== 1'b0 || slot_err !== 1'b0) begin failures++; $display("FAIL reset_flags got %b/%b want 0/0", test_has_ended, slot_err); end
        checks++; if (dut.r_state !== StRun) begin failures++; $display("FAIL reset_state got %0d want %0d", dut.r_state, StRun); end
    endtask

    task automatic test_in_order();
        out_ready = 1'b1;
        drive(1'b1, 30'h0000_02A5, 4'd5);
        tick();
        checks++; if (out_valid !== 1'b1 || out_buffer !== 30'h0000_02A5 || out_count !== 4'd5) begin failures++; $display("FAIL order_w0 got %b %h %0d want 1 000002a5 5", out_valid, out_buffer, out_count); end
        drive(1'b1, 30'h1234_5678, 4'd15);
        tick();
        checks++; if (out_valid !== 1'b1 || out_buffer !== 30'h1234_5678 || out_count !== 4'd15) begin failures++; $display("FAIL order_w1 got %b %h %0d want 1 12345678 15", out_valid, out_buffer, out_count); end
        drive(1'b1, 30'h0000_0003, 4'd1);
        tick();
        checks++; if (out_valid !== 1'b1 || out_buffer !== 30'h0000_0003 || out_count !== 4'd1) begin failures++; $display("FAIL order_w2 got %b %h %0d want 1 00000003 1", out_valid, out_buffer, out_count); end
        drive(1'b0, 30'h0, 4'd0);
        tick();
        checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin failures++; $display("FAIL order_drained got %b/%0d want 0/0", out_valid, level); end
        checks++; if (total_slots !== 32'd21) begin failures++; $display("FAIL order_total got %0d want 21", total_slots); end
        // A zero-count word must vanish without a trace.
        drive(1'b1, 30'h0000_0055, 4'd0);
        tick();
        drive(1'b0, 30'h0, 4'd0);
        checks++; if (out_valid !== 1'b0 || level !== 4'd0 || total_slots !== 32'd21) begin failures++; $display("FAIL zero_count got %b/%0d/%0d want 0/0/21", out_valid, level, total_slots); end
        checks++; if (slot_err !== 1'b0) begin failures++; $display("FAIL order_slot_err got %b want 0", slot_err); end
    endtask

    task automatic test_overflow_and_full();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ovf_word(i), 4'd15);
            tick();
        end
        drive(1'b0, 30'h0, 4'd0);
        checks++; if (level !== 4'd8) begin failures++; $display("FAIL ovf_level got %0d want 8", level); end
        checks++; if (overflow_cnt !== 16'd2) begin failures++; $display("FAIL ovf_count got %0d want 2", overflow_cnt); end
        checks++; if (total_slots !== 32'd120) begin failures++; $display("FAIL ovf_total got %0d want 120", total_slots); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_buffer !== ovf_word(0) || out_count !== 4'd15) begin failures++; $display("FAIL ovf_hold got %b %h %0d want 1 %h 15", out_valid, out_buffer, out_count, ovf_word(0)); end
        // Push into a full FIFO while the head leaves.
        drive(1'b1, 30'h3FFF_0000, 4'd15);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 30'h0, 4'd0);
        checks++; if (level !== 4'd8 || overflow_cnt !== 16'd2) begin failures++; $display("FAIL full_pushpop got %0d/%0d want 8/2", level, overflow_cnt); end
        checks++; if (total_slots !== 32'd135) begin failures++; $display("FAIL full_pushpop_total got %0d want 135", total_slots); end
        checks++; if (out_buffer !== ovf_word(1)) begin failures++; $display("FAIL drain_1 got %h want %h", out_buffer, ovf_word(1)); end
        for (int k = 2; k < 8; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_buffer !== ovf_word(k)) begin failures++; $display("FAIL drain_%0d got %b %h want 1 %h", k, out_valid, out_buffer, ovf_word(k)); end
        end
        tick();
        checks++; if (out_valid !== 1'b1 || out_buffer !== 30'h3FFF_0000) begin failures++; $display("FAIL drain_last got %b %h want 1 3fff0000", out_valid, out_buffer); end
        tick();
        checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin failures++; $display("FAIL drain_empty got %b/%0d want 0/0", out_valid, level); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 30'h0000_0111, 4'd3);
        tick();
        drive(1'b1, 30'h0000_0002, 4'd2);
        tick();
        drive(1'b1, 30'h0000_0001, 4'd1);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        checks++; if (level !== 4'd3) begin failures++; $display("FAIL flush_level got %0d want 3", level); end
        checks++; if (dut.r_state !== StFlush || test_has_ended !== 1'b0) begin failures++; $display("FAIL flush_state got %0d/%b want %0d/0", dut.r_state, test_has_ended, StFlush); end
        // Keep offering words during the drain; all must be ignored.
        drive(1'b1, 30'h0000_0003, 4'd1);
        out_ready = 1'b1;
        checks++; if (out_buffer !== 30'h0000_0111) begin failures++; $display("FAIL flush_head got %h want 00000111", out_buffer); end
        tick();
        checks++; if (level !== 4'd2 || out_buffer !== 30'h0000_0002) begin failures++; $display("FAIL flush_pop1 got %0d %h want 2 00000002", level, out_buffer); end
        tick();
        checks++; if (level !== 4'd1 || out_buffer !== 30'h0000_0001) begin failures++; $display("FAIL flush_pop2 got %0d %h want 1 00000001", level, out_buffer); end
        tick();
        checks++; if (level !== 4'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_pop3 got %0d/%b want 0/0", level, out_valid); end
        tick();
        checks++; if (test_has_ended !== 1'b1) begin failures++; $display("FAIL flush_ended got %b want 1", test_has_ended); end
        tick();
        tick();
        checks++; if (test_has_ended !== 1'b1 || level !== 4'd0 || total_slots !== 32'd6) begin failures++; $display("FAIL ended_ignore got %b/%0d/%0d want 1/0/6", test_has_ended, level, total_slots); end
        drive(1'b0, 30'h0, 4'd0);
    endtask

    task automatic test_reset_in_flush();
        out_ready = 1'b0;
        do_reset();
        checks++; if (test_has_ended !== 1'b0 || dut.r_state !== StRun) begin failures++; $display("FAIL reset_from_ended got %b/%0d want 0/%0d", test_has_ended, dut.r_state, StRun); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 30'(i % 3 + 1), 4'd1);
            tick();
        end
        drive(1'b0, 30'h0, 4'd0);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        checks++; if (level !== 4'd4 || dut.r_state !== StFlush) begin failures++; $display("FAIL pre_reset got %0d/%0d want 4/%0d", level, dut.r_state, StFlush); end
        do_reset();
        checks++; if (level !== 4'd0 || out_valid !== 1'b0 || test_has_ended !== 1'b0) begin failures++; $display("FAIL flush_reset got %0d/%b/%b want 0/0/0", level, out_valid, test_has_ended); end
        checks++; if (dut.r_state !== StRun || total_slots !== 32'd0) begin failures++; $display("FAIL flush_reset_state got %0d/%0d want %0d/0", dut.r_state, total_slots, StRun); end
        drive(1'b1, 30'h0000_0002, 4'd1);
        tick();
        drive(1'b0, 30'h0, 4'd0);
        checks++; if (level !== 4'd1 || out_buffer !== 30'h0000_0002) begin failures++; $display("FAIL restart_push got %0d %h want 1 00000002", level, out_buffer); end
    endtask

    task automatic test_slot_err();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 30'h0000_0010, 4'd2);
        tick();
        checks++; if (out_valid !== 1'b1 || out_buffer !== 30'h0000_0010 || out_count !== 4'd2) begin failures++; $display("FAIL bad_word_out got %b %h %0d want 1 00000010 2", out_valid, out_buffer, out_count); end
        checks++; if (slot_err !== ExpSlotErr) begin failures++; $display("FAIL slot_err got %b want %b", slot_err, ExpSlotErr); end
        drive(1'b1, 30'h0000_0001, 4'd1);
        tick();
        drive(1'b0, 30'h0, 4'd0);
        tick();
        checks++; if (slot_err !== ExpSlotErr) begin failures++; $display("FAIL slot_err_sticky got %b want %b", slot_err, ExpSlotErr); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_overflow_and_full();
        test_flush();
        test_reset_in_flush();
        test_slot_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
